control_unit: RTL and testbench
===============================

# control_unit

Finite-state controller that sequences the 8-bit accumulator datapath: instruction register, 5-bit PC with jump mux, 32×8 RAM with PC/IR address mux, A-register input mux and add/sub unit. It fetches, decodes and executes one 3-bit-opcode instruction at a time from the datapath's status bits (IR, Aeq0, Apos) and drives every datapath control strobe. It also handles the user Enter handshake for the INPUT instruction and powers up the RAM.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the Enter/Step synchronizers (minimum 2).

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low; forces INIT.
- IR  in  3  opcode field of the instruction register.
- Aeq0  in  1  A == 0.
- Apos  in  1  A[7] == 0.
- Enter  in  1  asynchronous user push-button for INPUT.
- Step  in  1  asynchronous single-step button (used only with CU_SINGLE_STEP_EN).
- IRload  out  1  load IR from RAM data.
- JMPmux  out  1  1 = PC next from IR[4:0], 0 = PC+1.
- PCload  out  1  load PC.
- Meminst  out  1  1 = RAM address from IR[4:0], 0 = from PC.
- MemWr  out  1  write A into RAM.
- Aload  out  1  load A.
- Sub  out  1  add/sub select, 1 = A − mem.
- Asel  out  2  A source: 00 add/sub, 01 Input, 10 RAM, 11 8'hFF.
- Initialize  out  1  RAM program-image load strobe.
- Halt  out  1  processor halted.
- State  out  4  current state code (debug).

## Operation
- Opcodes: 000 LOAD A←M[a]; 001 STORE M[a]←A; 010 ADD A←A+M[a]; 011 SUB A←A−M[a]; 100 INPUT A←Input; 101 JZ PC←a if A==0; 110 JPOS PC←a if A≥0; 111 HALT.
- States and codes: INIT 0, FETCH 1, DECODE 2, LOAD 3, STORE 4, ADD 5, SUB 6, IN_WAIT 7, IN_LOAD 8, JZ 9, JPOS 10, HALT 11, STEP_WAIT 12. Codes 13–15 are illegal and go to INIT.
- Unlisted outputs are 0 in every state. Asel defaults to 00.
- INIT: Initialize=1 for exactly one cycle, then FETCH.
- FETCH: IRload=1, PCload=1, Meminst=0, JMPmux=0. IR←M[PC] and PC←PC+1. Then DECODE.
- DECODE: Meminst=1. Next state is selected by IR: 000→LOAD, 001→STORE, 010→ADD, 011→SUB, 100→IN_WAIT, 101→JZ, 110→JPOS, 111→HALT.
- LOAD: Meminst=1, Asel=10, Aload=1.
- STORE: Meminst=1, MemWr=1.
- ADD: Meminst=1, Asel=00, Sub=0, Aload=1.
- SUB: Meminst=1, Asel=00, Sub=1, Aload=1.
- IN_WAIT: all strobes 0. Stays until a synchronized Enter rising edge is detected, then IN_LOAD.
- IN_LOAD: Asel=01, Aload=1.
- JZ: JMPmux=1, PCload=Aeq0 (Mealy).
- JPOS: JMPmux=1, PCload=Apos (Mealy).
- After LOAD, STORE, ADD, SUB, IN_LOAD, JZ or JPOS, the next state is FETCH.
- HALT: Halt=1, all strobes 0. HALT is terminal; only Reset leaves it.
- Enter and Step each pass through a SYNC_STAGES flop chain plus one edge-detect flop. One press produces exactly one edge pulse. A held button does not retrigger. An Enter edge that occurs outside IN_WAIT is discarded.

## Timing
- Reset low: state=INIT, all sync flops cleared, every output 0 except State=0. Initialize rises in the first cycle after Reset deasserts.
- Reset asserted mid-instruction aborts immediately. Datapath registers are reset by their own Reset; no partial MemWr may occur after Reset falls.
- Latency: 3 cycles for LOAD, STORE, ADD, SUB, JZ, JPOS.
- INPUT latency: 3 cycles plus the Enter wait. IN_LOAD occurs at most SYNC_STAGES+2 cycles after Enter rises.
- A taken jump makes the next FETCH read M[IR[4:0]]. PC wraps from 31 to 0 through the datapath's 5-bit increment; the controller takes no action.
- MemWr is high for exactly one cycle per STORE.
- Outputs are registered-state decodes. The JZ/JPOS PCload is the only combinational path from inputs to outputs.

## Configuration
- CU_SINGLE_STEP_EN defined: every transition into FETCH (from INIT and from each execute state) goes through STEP_WAIT instead. STEP_WAIT holds all strobes 0 and advances to FETCH on a synchronized Step rising edge, so exactly one instruction runs per press.
- CU_SINGLE_STEP_EN undefined: STEP_WAIT is never entered, Step is ignored, and its synchronizer is removed.

## Test plan
- Reset low for 3 cycles, then high -> State=0 and all outputs 0 during reset. Initialize=1 for one cycle, then State=1.
- RAM {0:LOAD 10, 1:ADD 11, 2:STORE 12, 3:HALT}, M[10]=5, M[11]=7 -> M[12]=12. Halt=1 at cycle 13 after INIT. MemWr is high for exactly one cycle.
- SUB giving 0 followed by JZ 20 -> PC=20 at the next FETCH. Repeat with A=1 -> PC advances sequentially and PCload stays 0 in JZ.
- JPOS with A=8'h80 -> not taken. JPOS with A=8'h7F -> taken.
- INPUT with Input=8'h3C: hold Enter low for 50 cycles -> State stays 7. Pulse Enter -> A=8'h3C within SYNC_STAGES+3 cycles. Hold Enter high across a second INPUT -> no load until Enter is released and pressed again.
- Pull Reset low during STORE -> no RAM write and State=0 immediately. With CU_SINGLE_STEP_EN defined, each Step pulse retires exactly one instruction.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: FSM sequencer for the 8-bit accumulator datapath.
// It fetches, decodes and executes one 3-bit-opcode instruction at a time,
// handles the Enter handshake for INPUT, and strobes the RAM image load.
// Optional build macro: CU_SINGLE_STEP_EN. When it is defined, every return
// to FETCH waits in STEP_WAIT for a synchronized Step press.
module control_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  input  logic       Step,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Initialize,
  output logic       Halt,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_LOAD      = 4'd3,
    S_STORE     = 4'd4,
    S_ADD       = 4'd5,
    S_SUB       = 4'd6,
    S_IN_WAIT   = 4'd7,
    S_IN_LOAD   = 4'd8,
    S_JZ        = 4'd9,
    S_JPOS      = 4'd10,
    S_HALT      = 4'd11,
    S_STEP_WAIT = 4'd12
  } state_t;

`ifdef CU_SINGLE_STEP_EN
  localparam state_t S_RESUME = S_STEP_WAIT;
`else
  localparam state_t S_RESUME = S_FETCH;
`endif

  state_t state;
  state_t state_next;

  // Low while Reset is held; INIT only raises Initialize once this is set,
  // so every output stays 0 during reset and Initialize appears right after.
  logic armed;

  // Enter synchronizer chain plus edge-detect flop.
  logic [SYNC_STAGES-1:0] enter_sync;
  logic                   enter_prev;
  logic                   enter_edge;

  // Shift the asynchronous Enter button into the clock domain.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      enter_sync <= '0;
      enter_prev <= 1'b0;
    end else begin
      enter_sync <= {enter_sync[SYNC_STAGES-2:0], Enter};
      enter_prev <= enter_sync[SYNC_STAGES-1];
    end
  end

  // A held button yields one pulse only: a rise is needed, not a level.
  assign enter_edge = enter_sync[SYNC_STAGES-1] & ~enter_prev;

`ifdef CU_SINGLE_STEP_EN
  logic [SYNC_STAGES-1:0] step_sync;
  logic                   step_prev;
  logic                   step_edge;

  // Shift the asynchronous Step button into the clock domain.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      step_sync <= '0;
      step_prev <= 1'b0;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], Step};
      step_prev <= step_sync[SYNC_STAGES-1];
    end
  end

  assign step_edge = step_sync[SYNC_STAGES-1] & ~step_prev;
`else
  // Step has no function in this build.
  logic unused_step;
  assign unused_step = Step;
`endif

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_INIT;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Next-state selection and state-decoded strobes (PCload is Mealy in jumps).
  always_comb begin
    state_next = state;
    IRload     = 1'b0;
    JMPmux     = 1'b0;
    PCload     = 1'b0;
    Meminst    = 1'b0;
    MemWr      = 1'b0;
    Aload      = 1'b0;
    Sub        = 1'b0;
    Asel       = 2'b00;
    Initialize = 1'b0;
    Halt       = 1'b0;
    State      = state;
    case (state)
      S_INIT: begin
        Initialize = armed;
        if (armed) state_next = S_RESUME;
      end
      S_FETCH: begin
        IRload     = 1'b1;
        PCload     = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        Meminst = 1'b1;
        case (IR)
          3'b000:  state_next = S_LOAD;
          3'b001:  state_next = S_STORE;
          3'b010:  state_next = S_ADD;
          3'b011:  state_next = S_SUB;
          3'b100:  state_next = S_IN_WAIT;
          3'b101:  state_next = S_JZ;
          3'b110:  state_next = S_JPOS;
          default: state_next = S_HALT;
        endcase
      end
      S_LOAD: begin
        Meminst    = 1'b1;
        Asel       = 2'b10;
        Aload      = 1'b1;
        state_next = S_RESUME;
      end
      S_STORE: begin
        Meminst    = 1'b1;
        MemWr      = 1'b1;
        state_next = S_RESUME;
      end
      S_ADD: begin
        Meminst    = 1'b1;
        Aload      = 1'b1;
        state_next = S_RESUME;
      end
      S_SUB: begin
        Meminst    = 1'b1;
        Sub        = 1'b1;
        Aload      = 1'b1;
        state_next = S_RESUME;
      end
      S_IN_WAIT: begin
        if (enter_edge) state_next = S_IN_LOAD;
      end
      S_IN_LOAD: begin
        Asel       = 2'b01;
        Aload      = 1'b1;
        state_next = S_RESUME;
      end
      S_JZ: begin
        JMPmux     = 1'b1;
        PCload     = Aeq0;
        state_next = S_RESUME;
      end
      S_JPOS: begin
        JMPmux     = 1'b1;
        PCload     = Apos;
        state_next = S_RESUME;
      end
      S_HALT: begin
        Halt = 1'b1;
      end
      S_STEP_WAIT: begin
`ifdef CU_SINGLE_STEP_EN
        if (step_edge) state_next = S_FETCH;
`else
        state_next = S_INIT;
`endif
      end
      default: state_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit with a small behavioural
// model of the accumulator datapath (PC, IR, A, 32x8 RAM) around it.
// Build macro CU_SINGLE_STEP_EN selects the single-step scenario set.
module tb_control_unit;

  localparam int SYNC_STAGES = 2;
`ifdef CU_SINGLE_STEP_EN
  localparam logic [3:0] EXP_AFTER_INIT = 4'd12;
`else
  localparam logic [3:0] EXP_AFTER_INIT = 4'd1;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Enter = 1'b0;
  logic       Step = 1'b0;
  logic [2:0] IR;
  logic       Aeq0, Apos;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic       Initialize, Halt;
  logic [3:0] State;

  int n_cmp = 0;
  int n_bad = 0;

  // Datapath model
  logic [7:0] ram [32];
  logic [7:0] prog_img [32];
  logic [4:0] pc;
  logic [7:0] ir, a, in_val;
  logic [4:0] addr;

  assign addr = Meminst ? ir[4:0] : pc;
  assign IR   = ir[7:5];
  assign Aeq0 = (a == 8'd0);
  assign Apos = ~a[7];

  control_unit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
    .Enter(Enter), .Step(Step), .IRload(IRload), .JMPmux(JMPmux),
    .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
    .Sub(Sub), .Asel(Asel), .Initialize(Initialize), .Halt(Halt),
    .State(State)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc <= 5'd0;
      ir <= 8'd0;
      a  <= 8'd0;
    end else begin
      if (Initialize) for (int k = 0; k < 32; k++) ram[k] <= prog_img[k];
      if (IRload) ir <= ram[addr];
      if (PCload) pc <= JMPmux ? ir[4:0] : pc + 5'd1;
      if (MemWr) ram[addr] <= a;
      if (Aload) begin
        case (Asel)
          2'b00: a <= Sub ? a - ram[addr] : a + ram[addr];
          2'b01: a <= in_val;
          2'b10: a <= ram[addr];
          default: a <= 8'hFF;
        endcase
      end
    end
  end

  task automatic clear_prog();
    for (int k = 0; k < 32; k++) prog_img[k] = 8'h00;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Enter = 1'b0;
    Step  = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cyc, output int cyc, output int wr_cnt,
                                output logic jpc, output bit timed_out);
    cyc = 0; wr_cnt = 0; jpc = 1'b0; timed_out = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge Clock); #1;
      if (MemWr) wr_cnt++;
      if (State == 4'd9 || State == 4'd10) jpc = PCload;
      if (Halt) begin
        cyc = i; timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge Clock); #1;
      if (State == s) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    clear_prog();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      outs = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel,
              Initialize, Halt, State, 3'b000};
      n_cmp++;
      if (outs !== 18'd0) begin
        n_bad++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
    end
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    n_cmp++;
    if (Initialize !== 1'b1 || State !== 4'd0) begin
      n_bad++; $display("FAIL init_cycle: Initialize=%b State=%0d want 1/0", Initialize, State);
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (Initialize !== 1'b0 || State !== EXP_AFTER_INIT) begin
      n_bad++; $display("FAIL after_init: Initialize=%b State=%0d want 0/%0d",
                        Initialize, State, EXP_AFTER_INIT);
    end
    $display("test_reset: State=%0d after init", State);
  endtask

  task automatic test_arith();
    int cyc, wr; logic jpc; bit to;
    clear_prog();
    prog_img[0] = 8'h0A; prog_img[1] = 8'h4B; prog_img[2] = 8'h2C; prog_img[3] = 8'hE0;
    prog_img[10] = 8'd5; prog_img[11] = 8'd7;
    do_reset();
    run_until_halt(40, cyc, wr, jpc, to);
    n_cmp++;
    if (to || cyc != 13) begin
      n_bad++; $display("FAIL arith_halt_cycle: got %0d (timeout=%0d) want 13", cyc, to);
    end
    n_cmp++;
    if (ram[12] !== 8'd12) begin
      n_bad++; $display("FAIL arith_store: M[12]=%0d want 12", ram[12]);
    end
    n_cmp++;
    if (wr != 1) begin
      n_bad++; $display("FAIL arith_memwr_count: got %0d want 1", wr);
    end
    repeat (5) @(posedge Clock); #1;
    n_cmp++;
    if (State !== 4'd11 || Halt !== 1'b1) begin
      n_bad++; $display("FAIL halt_terminal: State=%0d Halt=%b want 11/1", State, Halt);
    end
    $display("test_arith: halt at %0d, M[12]=%0d, writes=%0d", cyc, ram[12], wr);
  endtask

  task automatic test_jump(input string name, input logic [7:0] op, input logic [7:0] m16,
                           input logic [7:0] m17, input logic use_sub,
                           input logic [4:0] exp_pc, input logic exp_jpc);
    int cyc, wr; logic jpc; bit to;
    clear_prog();
    prog_img[0] = 8'h10;
    if (use_sub) begin
      prog_img[1] = 8'h71; prog_img[2] = op; prog_img[3] = 8'hE0;
    end else begin
      prog_img[1] = op; prog_img[2] = 8'hE0;
    end
    prog_img[16] = m16; prog_img[17] = m17; prog_img[20] = 8'hE0;
    do_reset();
    run_until_halt(40, cyc, wr, jpc, to);
    n_cmp++;
    if (to || pc !== exp_pc) begin
      n_bad++; $display("FAIL %s_pc: pc=%0d (timeout=%0d) want %0d", name, pc, to, exp_pc);
    end
    n_cmp++;
    if (jpc !== exp_jpc) begin
      n_bad++; $display("FAIL %s_pcload: got %b want %b", name, jpc, exp_jpc);
    end
    $display("test_jump %s: A=%h pc=%0d PCload=%b", name, a, pc, jpc);
  endtask

  task automatic test_input();
    int cyc, wr; logic jpc; bit to; bit loaded;
    clear_prog();
    prog_img[0] = 8'h80; prog_img[1] = 8'h80; prog_img[2] = 8'hE0;
    in_val = 8'h3C;
    do_reset();
    wait_state(4'd7, 20, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL input_reach_wait: State=%0d want 7", State); end
    repeat (50) @(posedge Clock); #1;
    n_cmp++;
    if (State !== 4'd7 || a !== 8'h00) begin
      n_bad++; $display("FAIL input_idle: State=%0d A=%h want 7/00", State, a);
    end
    @(negedge Clock); Enter = 1'b1;
    loaded = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 3; i++) begin
      @(posedge Clock); #1;
      if (a === 8'h3C) begin loaded = 1'b1; break; end
    end
    n_cmp++;
    if (!loaded) begin n_bad++; $display("FAIL input_latency: A=%h want 3c", a); end
    in_val = 8'h55;
    repeat (20) @(posedge Clock); #1;
    n_cmp++;
    if (State !== 4'd7 || a !== 8'h3C) begin
      n_bad++; $display("FAIL input_held: State=%0d A=%h want 7/3c", State, a);
    end
    @(negedge Clock); Enter = 1'b0;
    repeat (5) @(posedge Clock); #1;
    n_cmp++;
    if (State !== 4'd7) begin
      n_bad++; $display("FAIL input_release: State=%0d want 7", State);
    end
    @(negedge Clock); Enter = 1'b1;
    repeat (3) @(negedge Clock);
    Enter = 1'b0;
    run_until_halt(20, cyc, wr, jpc, to);
    n_cmp++;
    if (to || a !== 8'h55) begin
      n_bad++; $display("FAIL input_second: A=%h (timeout=%0d) want 55", a, to);
    end
    $display("test_input: final A=%h", a);
  endtask

  task automatic test_reset_in_store();
    bit to;
    clear_prog();
    prog_img[0] = 8'h2C; prog_img[1] = 8'hE0; prog_img[12] = 8'hAA;
    do_reset();
    wait_state(4'd4, 20, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL store_reach: State=%0d want 4", State); end
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (State !== 4'd0 || MemWr !== 1'b0) begin
      n_bad++; $display("FAIL store_abort: State=%0d MemWr=%b want 0/0", State, MemWr);
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (ram[12] !== 8'hAA) begin
      n_bad++; $display("FAIL store_no_write: M[12]=%h want aa", ram[12]);
    end
    $display("test_reset_in_store: M[12]=%h State=%0d", ram[12], State);
  endtask

`ifdef CU_SINGLE_STEP_EN
  task automatic test_single_step();
    clear_prog();
    prog_img[0] = 8'h0A; prog_img[1] = 8'h4B; prog_img[2] = 8'h2C; prog_img[3] = 8'hE0;
    prog_img[10] = 8'd5; prog_img[11] = 8'd7;
    do_reset();
    repeat (10) @(posedge Clock); #1;
    n_cmp++;
    if (State !== 4'd12 || pc !== 5'd0) begin
      n_bad++; $display("FAIL step_idle: State=%0d pc=%0d want 12/0", State, pc);
    end
    for (int s = 1; s <= 2; s++) begin
      @(negedge Clock); Step = 1'b1;
      repeat (3) @(negedge Clock);
      Step = 1'b0;
      repeat (10) @(posedge Clock); #1;
      n_cmp++;
      if (State !== 4'd12 || pc !== 5'(s) || a !== ((s == 1) ? 8'd5 : 8'd12)) begin
        n_bad++; $display("FAIL step_%0d: State=%0d pc=%0d A=%0d", s, State, pc, a);
      end
      $display("test_single_step: press %0d pc=%0d A=%0d", s, pc, a);
    end
  endtask
`endif

  initial begin
    in_val = 8'h00;
    test_reset();
`ifdef CU_SINGLE_STEP_EN
    test_single_step();
`else
    test_arith();
    test_jump("jz_taken", 8'hB4, 8'd9, 8'd9, 1'b1, 5'd21, 1'b1);
    test_jump("jz_not", 8'hB4, 8'd10, 8'd9, 1'b1, 5'd4, 1'b0);
    test_jump("jpos_neg", 8'hD4, 8'h80, 8'h00, 1'b0, 5'd3, 1'b0);
    test_jump("jpos_pos", 8'hD4, 8'h7F, 8'h00, 1'b0, 5'd21, 1'b1);
    test_input();
    test_reset_in_store();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
